mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Bus-initiator block that drives the single-cycle data-memory port (address / MemWrite / MemRead / WriteData / ReadData) to copy a block of aligned 32-bit words from a source to a destination region. Sits beside the CPU datapath as a simple DMA helper: software-visible registers load `src_addr`, `dst_addr` and `word_count`, pulse `start`, then poll `busy` or wait for `done`. The memory-side ports are the initiator end of the combinational-read, posedge-write data-memory protocol.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data word width
- `LEN_W`, 8, width of word count and progress counter

- `clock` in 1 — single clock, all state on posedge
- `reset` in 1 — asynchronous, active-high; clears all state
- `start` in 1 — one-cycle request; honoured only in IDLE
- `abort` in 1 — terminate transfer in progress
- `src_addr` in ADDR_W — byte address of first source word
- `dst_addr` in ADDR_W — byte address of first destination word
- `word_count` in LEN_W — words to copy; 0 is legal
- `busy` out 1 — high while in READ or WRITE
- `done` out 1 — one-cycle pulse at completion, abort or error
- `err` out 1 — misalignment flag; held until next accepted `start`
- `words_done` out LEN_W — words fully written in current/last transfer
- `mem_address` out ADDR_W — to memory `address`
- `mem_MemRead` out 1 — to memory `MemRead`
- `mem_MemWrite` out 1 — to memory `MemWrite`
- `mem_WriteData` out DATA_W — to memory `WriteData`
- `mem_ReadData` in DATA_W — from memory `ReadData` (combinational, same cycle as address)

## Operation
- States: IDLE, READ, WRITE, FINISH.
- IDLE + `start`: latch src/dst/count into `src_ptr`, `dst_ptr`, `remaining`; clear `err`, `words_done`.
  - `src_addr[1:0]` or `dst_addr[1:0]` nonzero → `err`=1, go FINISH, no memory access.
  - `word_count`==0 → FINISH, no memory access, `err`=0.
  - else → READ.
- READ: `mem_address`=`src_ptr`, `mem_MemRead`=1, `mem_MemWrite`=0; capture `mem_ReadData` into `data_q` at the clock edge; → WRITE.
- WRITE: `mem_address`=`dst_ptr`, `mem_MemWrite`=1, `mem_MemRead`=0, `mem_WriteData`=`data_q`; at edge: `src_ptr`+=4, `dst_ptr`+=4, `remaining`-=1, `words_done`+=1; → FINISH if `remaining`==1, else READ.
- FINISH: `done`=1 for exactly one cycle; → IDLE.
- In IDLE/FINISH, all memory strobes are 0 and `mem_address` holds its last value.
- Pointer arithmetic is modulo 2^ADDR_W; carry is discarded. The wrap at the memory's index width is the memory's concern.
- Forward copy, one word at a time: overlapping regions with dst > src replicate source data. This is defined behaviour, not an error.
- `abort`:
  - In READ → FINISH, no write.
  - In WRITE → write completes this cycle, counters update, → FINISH.
  - In IDLE/FINISH → ignored.
  - Abort does not set `err`.
- `start` outside IDLE is ignored, with no latching.

## Timing
- Memory strobes, address and write data decode from registered state only; there is no combinational path from `start`/`abort` to memory ports.
- Transfer of N≥1 words: `start` sampled at edge 0; READ of word 0 in cycle 1; `done` high in cycle 2N+1; IDLE in cycle 2N+2; next `start` accepted from cycle 2N+1's edge onward (in IDLE).
- Zero-length or misaligned: `done` in cycle 1.
- `busy` = (state==READ || state==WRITE).
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `words_done`=0, `mem_address`=0, `mem_MemRead`=0, `mem_MemWrite`=0, `mem_WriteData`=0.
- Reset mid-transfer aborts immediately, with no pending write and no `done` pulse.

## Configuration
- `MEM_COPY_FILL_EN` defined: adds inputs `fill` (1) and `fill_value` (DATA_W), latched on `start`. With `fill`=1 the READ state is skipped: WRITE repeats with `mem_WriteData`=`fill_value`, 1 cycle per word, so `done` arrives in cycle N+1. Only `dst_addr` alignment is checked.
- Undefined: ports absent, copy-only behaviour as above.

## Structure
- Shared package `mem_copy_pkg`: state enum (IDLE/READ/WRITE/FINISH), word stride constant `WORD_BYTES`=4, alignment mask constant.
- Single module; no sub-module. The FSM and counters are small enough to stay flat.

## Test plan
- Copy: src=0x00, dst=0x40, count=4, memory words 0..3 = 0x11,0x22,0x33,0x44 → words 16..19 hold the same values; `done` in cycle 9; `words_done`=4; `err`=0.
- Zero length: count=0 → no MemRead/MemWrite ever high; `done` in cycle 1.
- Misaligned: src=0x02 → `err`=1, `done` in cycle 1, no memory access; next aligned `start` clears `err`.
- Abort: count=8, `abort` during 3rd WRITE → exactly 3 words written, `words_done`=3, `done` next cycle, word 3 of destination unchanged.
- Async reset asserted during READ of word 2 → all outputs at reset values immediately; no `done` pulse; destination words ≥2 untouched.
- Overlap (dst=src+4, count=3, src words A,B,C) → destination reads A,A,A; with `MEM_COPY_FILL_EN` and fill=1, value 0xDEADBEEF, count=5 → 5 words written, `done` in cycle 6.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy engine: FSM states, word stride and alignment helpers.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return ((addr_lsb & ALIGN_MASK) == 2'b00);
  endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Word-at-a-time DMA copy engine driving a combinational-read / posedge-write data memory.
// Optional fill mode (repeated constant write, no reads) is enabled with MEM_COPY_FILL_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  word_count,
`ifdef MEM_COPY_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_ReadData
);

  state_t              state_r;
  logic [ADDR_W-1:0]   src_ptr_r;
  logic [ADDR_W-1:0]   dst_ptr_r;
  logic [LEN_W-1:0]    remaining_r;
  logic [LEN_W-1:0]    words_done_r;
  logic                fill_r;
  logic [DATA_W-1:0]   fill_value_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic [ADDR_W-1:0]   mem_address_r;
  logic                mem_read_r;
  logic                mem_write_r;
  logic [DATA_W-1:0]   mem_wdata_r;

  logic                fill_req_s;
  logic [DATA_W-1:0]   fill_value_s;
  logic                misaligned_s;
  logic                last_word_s;
  logic [ADDR_W-1:0]   next_src_s;
  logic [ADDR_W-1:0]   next_dst_s;

`ifdef MEM_COPY_FILL_EN
  assign fill_req_s   = fill;
  assign fill_value_s = fill_value;
`else
  assign fill_req_s   = 1'b0;
  assign fill_value_s = {DATA_W{1'b0}};
`endif

  // Fill transfers never read, so only the destination must be word aligned.
  always_comb begin
    misaligned_s = 1'b0;
    if (!is_aligned(dst_addr[1:0])) begin
      misaligned_s = 1'b1;
    end else if (!fill_req_s && !is_aligned(src_addr[1:0])) begin
      misaligned_s = 1'b1;
    end else begin
      misaligned_s = 1'b0;
    end
  end

  assign last_word_s = (remaining_r == LEN_W'(1));
  assign next_src_s  = src_ptr_r + ADDR_W'(WORD_BYTES);
  assign next_dst_s  = dst_ptr_r + ADDR_W'(WORD_BYTES);

  // Transfer FSM; memory-side outputs are registered alongside the state they belong to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      src_ptr_r     <= {ADDR_W{1'b0}};
      dst_ptr_r     <= {ADDR_W{1'b0}};
      remaining_r   <= {LEN_W{1'b0}};
      words_done_r  <= {LEN_W{1'b0}};
      fill_r        <= 1'b0;
      fill_value_r  <= {DATA_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      mem_address_r <= {ADDR_W{1'b0}};
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_wdata_r   <= {DATA_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            src_ptr_r    <= src_addr;
            dst_ptr_r    <= dst_addr;
            remaining_r  <= word_count;
            words_done_r <= {LEN_W{1'b0}};
            fill_r       <= fill_req_s;
            fill_value_r <= fill_value_s;
            err_r        <= 1'b0;
            if (misaligned_s) begin
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              state_r <= ST_FINISH;
            end else if (word_count == {LEN_W{1'b0}}) begin
              done_r  <= 1'b1;
              state_r <= ST_FINISH;
            end else if (fill_req_s) begin
              busy_r        <= 1'b1;
              mem_address_r <= dst_addr;
              mem_write_r   <= 1'b1;
              mem_wdata_r   <= fill_value_s;
              state_r       <= ST_WRITE;
            end else begin
              busy_r        <= 1'b1;
              mem_address_r <= src_addr;
              mem_read_r    <= 1'b1;
              state_r       <= ST_READ;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_READ: begin
          mem_read_r <= 1'b0;
          if (abort) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_FINISH;
          end else begin
            mem_wdata_r   <= mem_ReadData;
            mem_address_r <= dst_ptr_r;
            mem_write_r   <= 1'b1;
            state_r       <= ST_WRITE;
          end
        end

        // The write strobed this cycle always lands, even when abort is raised.
        ST_WRITE: begin
          src_ptr_r    <= next_src_s;
          dst_ptr_r    <= next_dst_s;
          remaining_r  <= remaining_r - LEN_W'(1);
          words_done_r <= words_done_r + LEN_W'(1);
          if (abort || last_word_s) begin
            busy_r      <= 1'b0;
            mem_write_r <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= ST_FINISH;
          end else if (fill_r) begin
            mem_address_r <= next_dst_s;
            mem_write_r   <= 1'b1;
            mem_wdata_r   <= fill_value_r;
            state_r       <= ST_WRITE;
          end else begin
            mem_address_r <= next_src_s;
            mem_write_r   <= 1'b0;
            mem_read_r    <= 1'b1;
            state_r       <= ST_READ;
          end
        end

        ST_FINISH: begin
          state_r <= ST_IDLE;
        end

        default: begin
          busy_r      <= 1'b0;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign words_done    = words_done_r;
  assign mem_address   = mem_address_r;
  assign mem_MemRead   = mem_read_r;
  assign mem_MemWrite  = mem_write_r;
  assign mem_WriteData = mem_wdata_r;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: a transaction-level model predicts the per-cycle bus trace
// and the final memory image; a single negedge process compares the DUT against it.
module tb_mem_copy_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src_addr = 32'h0;
  logic [31:0] dst_addr = 32'h0;
  logic [7:0]  word_count = 8'h0;
  logic        fill_i = 1'b0;
  logic [31:0] fill_val_i = 32'h0;
  logic        busy, done, err, mem_MemRead, mem_MemWrite;
  logic [7:0]  words_done;
  logic [31:0] mem_address, mem_WriteData, mem_ReadData;

  logic [31:0] mem [0:255];
  logic [31:0] model_mem [0:255];

  mem_copy_engine dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
`ifdef MEM_COPY_FILL_EN
    .fill(fill_i), .fill_value(fill_val_i),
`endif
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .mem_address(mem_address), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_WriteData(mem_WriteData), .mem_ReadData(mem_ReadData)
  );

  always #5 clock = ~clock;

  assign mem_ReadData = mem[mem_address[9:2]];
  always @(posedge clock) if (mem_MemWrite) mem[mem_address[9:2]] <= mem_WriteData;

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected per-cycle trace, index = cycles after the start edge
  int          exp_len;
  logic        exp_busy [64];
  logic        exp_rd [64];
  logic        exp_wr [64];
  logic        exp_done [64];
  logic        exp_err [64];
  logic [31:0] exp_addr [64];
  logic [31:0] exp_wdata [64];
  logic [7:0]  exp_wd [64];
  logic [31:0] last_addr = 32'h0;

  task automatic put(input int k, input logic b, input logic rd, input logic wr, input logic dn,
                     input logic [31:0] a, input logic [31:0] wdat, input int wd, input logic e);
    exp_busy[k] = b; exp_rd[k] = rd; exp_wr[k] = wr; exp_done[k] = dn;
    exp_addr[k] = a; exp_wdata[k] = wdat; exp_wd[k] = 8'(wd); exp_err[k] = e;
  endtask

  task automatic build_model(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                             input int abort_at, input logic fl, input logic [31:0] fv);
    int k, wd;
    logic mis, stop;
    logic [31:0] sa, da, d;
    mis = (dst[1:0] != 2'b00) || (!fl && (src[1:0] != 2'b00));
    k = 1; wd = 0; stop = 1'b0;
    if (!mis) begin
      for (int i = 0; i < cnt && !stop; i++) begin
        sa = src + 32'(4 * i);
        da = dst + 32'(4 * i);
        if (!fl) begin
          put(k, 1'b1, 1'b1, 1'b0, 1'b0, sa, 32'h0, wd, 1'b0);
          last_addr = sa;
          if (abort_at == k) stop = 1'b1;
          k++;
        end
        if (!stop) begin
          d = fl ? fv : model_mem[sa[9:2]];
          put(k, 1'b1, 1'b0, 1'b1, 1'b0, da, d, wd, 1'b0);
          model_mem[da[9:2]] = d;
          last_addr = da;
          wd++;
          if (abort_at == k) stop = 1'b1;
          k++;
        end
      end
    end
    put(k,     1'b0, 1'b0, 1'b0, 1'b1, last_addr, 32'h0, wd, mis);
    put(k + 1, 1'b0, 1'b0, 1'b0, 1'b0, last_addr, 32'h0, wd, mis);
    exp_len = k + 1;
  endtask

  logic chk_en = 1'b0;
  int   cyc = 0;
  int   done_cyc = 0;
  logic strobe_seen = 1'b0;

  // single compare process: DUT outputs against the model trace, mid-cycle
  always @(negedge clock) begin
    if (chk_en) begin
      cyc++;
      chk("busy", {31'h0, busy}, {31'h0, exp_busy[cyc]});
      chk("done", {31'h0, done}, {31'h0, exp_done[cyc]});
      chk("err", {31'h0, err}, {31'h0, exp_err[cyc]});
      chk("MemRead", {31'h0, mem_MemRead}, {31'h0, exp_rd[cyc]});
      chk("MemWrite", {31'h0, mem_MemWrite}, {31'h0, exp_wr[cyc]});
      chk("address", mem_address, exp_addr[cyc]);
      chk("words_done", {24'h0, words_done}, {24'h0, exp_wd[cyc]});
      if (exp_wr[cyc]) chk("WriteData", mem_WriteData, exp_wdata[cyc]);
      if (done && done_cyc == 0) done_cyc = cyc;
      if (mem_MemRead || mem_MemWrite) strobe_seen = 1'b1;
      if (cyc >= exp_len) chk_en = 1'b0;
    end
  end

  task automatic check_image(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) bad++;
    chk(name, 32'(bad), 32'h0);
  endtask

  task automatic run(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                     input int abort_at, input logic fl, input logic [31:0] fv);
    build_model(src, dst, cnt, abort_at, fl, fv);
    @(negedge clock); #1;
    src_addr = src; dst_addr = dst; word_count = 8'(cnt);
    fill_i = fl; fill_val_i = fv; start = 1'b1;
    cyc = 0; done_cyc = 0; strobe_seen = 1'b0; chk_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= exp_len; k++) begin
      @(negedge clock); #1;
      abort = (k == abort_at);
      // a start mid-transfer must be ignored entirely
      if (k == 2 && exp_busy[2]) begin
        start = 1'b1; src_addr = 32'h3F0; dst_addr = 32'h3F4; word_count = 8'd1;
      end else begin
        start = 1'b0;
      end
    end
    abort = 1'b0; start = 1'b0;
    chk("trace_complete", {31'h0, chk_en}, 32'h0);
    check_image("mem_image");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[8'hC0] = 32'hAAAA_0001; mem[8'hC1] = 32'hBBBB_0002; mem[8'hC2] = 32'hCCCC_0003;
    for (int i = 0; i < 256; i++) model_mem[i] = mem[i];

    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_words_done", {24'h0, words_done}, 32'h0);
    chk("rst_address", mem_address, 32'h0);
    chk("rst_MemRead", {31'h0, mem_MemRead}, 32'h0);
    chk("rst_MemWrite", {31'h0, mem_MemWrite}, 32'h0);
    chk("rst_WriteData", mem_WriteData, 32'h0);
    reset = 1'b0;

    // basic copy of 4 words
    run(32'h0, 32'h40, 4, 0, 1'b0, 32'h0);
    chk("copy_done_cycle", 32'(done_cyc), 32'd9);
    chk("copy_words_done", {24'h0, words_done}, 32'd4);
    chk("copy_err", {31'h0, err}, 32'h0);
    chk("copy_w16", mem[16], 32'h11);
    chk("copy_w17", mem[17], 32'h22);
    chk("copy_w18", mem[18], 32'h33);
    chk("copy_w19", mem[19], 32'h44);

    // zero length
    run(32'h80, 32'hC0, 0, 0, 1'b0, 32'h0);
    chk("zero_done_cycle", 32'(done_cyc), 32'd1);
    chk("zero_no_strobe", {31'h0, strobe_seen}, 32'h0);

    // misaligned source, then an aligned start clears err
    run(32'h02, 32'h60, 2, 0, 1'b0, 32'h0);
    chk("mis_err", {31'h0, err}, 32'h1);
    chk("mis_done_cycle", 32'(done_cyc), 32'd1);
    chk("mis_no_strobe", {31'h0, strobe_seen}, 32'h0);
    run(32'h10, 32'h50, 1, 0, 1'b0, 32'h0);
    chk("realign_err", {31'h0, err}, 32'h0);

    // abort during the third write
    run(32'h100, 32'h200, 8, 6, 1'b0, 32'h0);
    chk("abort_done_cycle", 32'(done_cyc), 32'd7);
    chk("abort_words_done", {24'h0, words_done}, 32'd3);
    chk("abort_err", {31'h0, err}, 32'h0);
    chk("abort_w2", mem[8'h82], 32'hA500_0042);
    chk("abort_w3_untouched", mem[8'h83], 32'hA500_0083);

    // overlapping forward copy replicates the first word
    run(32'h300, 32'h304, 3, 0, 1'b0, 32'h0);
    chk("overlap_w1", mem[8'hC1], 32'hAAAA_0001);
    chk("overlap_w2", mem[8'hC2], 32'hAAAA_0001);
    chk("overlap_w3", mem[8'hC3], 32'hAAAA_0001);

`ifdef MEM_COPY_FILL_EN
    run(32'h1, 32'h3A0, 5, 0, 1'b1, 32'hDEAD_BEEF);
    chk("fill_done_cycle", 32'(done_cyc), 32'd6);
    chk("fill_words_done", {24'h0, words_done}, 32'd5);
    chk("fill_w0", mem[8'hE8], 32'hDEAD_BEEF);
    chk("fill_w4", mem[8'hEC], 32'hDEAD_BEEF);
`endif

    // async reset during READ of word 2
    @(negedge clock); #1;
    src_addr = 32'h0; dst_addr = 32'h380; word_count = 8'd8; fill_i = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    chk("pre_rst_read", {31'h0, mem_MemRead}, 32'h1);
    chk("pre_rst_addr", mem_address, 32'h8);
    reset = 1'b1;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    chk("arst_MemRead", {31'h0, mem_MemRead}, 32'h0);
    chk("arst_MemWrite", {31'h0, mem_MemWrite}, 32'h0);
    chk("arst_address", mem_address, 32'h0);
    chk("arst_words_done", {24'h0, words_done}, 32'h0);
    chk("arst_WriteData", mem_WriteData, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("arst_no_done", {31'h0, done}, 32'h0);
    end
    reset = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
      chk("post_rst_idle", {30'h0, busy, done}, 32'h0);
    end
    model_mem[8'hE0] = model_mem[0];
    model_mem[8'hE1] = model_mem[1];
    last_addr = 32'h0;
    check_image("arst_image");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
